// File: rtl/lifegame_pkg.sv
// Shared constants and types for the Life grid pattern loader.
// The grid is 2^GRID_BITS square; pattern offsets are relative to an origin cell.
package lifegame_pkg;

  localparam int GRID_BITS      = 6;
  localparam int DEFAULT_ORIGIN = 30;
  localparam int ROM_IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_GLIDER  = 2'd0,
    PAT_BLINKER = 2'd1,
    PAT_BLOCK   = 2'd2,
    PAT_RPENT   = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
    logic       last;
  } rom_entry_t;

endpackage

// File: rtl/pattern_writer_if.sv
// Bundle of the control inputs and write/step outputs of pattern_writer.
interface pattern_writer_if #(
  parameter int GRID_BITS = lifegame_pkg::GRID_BITS
);
  logic                 start;
  logic [1:0]           pattern_sel;
  logic                 run_en;
  logic                 write_en;
  logic [GRID_BITS-1:0] wAddrR;
  logic [GRID_BITS-1:0] wAddrC;
  logic                 write_data;
  logic                 change_state;
  logic                 busy;
  logic                 done;

  modport master (
    output start, pattern_sel, run_en,
    input  write_en, wAddrR, wAddrC, write_data, change_state, busy, done
  );

  modport slave (
    input  start, pattern_sel, run_en,
    output write_en, wAddrR, wAddrC, write_data, change_state, busy, done
  );
endinterface

// File: rtl/pattern_rom.sv
// Combinational (dr,dc) offset table for the seed patterns; last marks the final cell.
module pattern_rom
  import lifegame_pkg::*;
(
  input  pattern_e             pattern,
  input  logic [ROM_IDX_W-1:0] index,
  output logic [1:0]           dr,
  output logic [1:0]           dc,
  output logic                 last
);

  rom_entry_t ent;

  always_comb begin
    ent = '{dr: 2'd0, dc: 2'd0, last: 1'b1};
    case (pattern)
      PAT_GLIDER: begin
        case (index)
          3'd0:    ent = '{2'd0, 2'd1, 1'b0};
          3'd1:    ent = '{2'd1, 2'd2, 1'b0};
          3'd2:    ent = '{2'd2, 2'd0, 1'b0};
          3'd3:    ent = '{2'd2, 2'd1, 1'b0};
          3'd4:    ent = '{2'd2, 2'd2, 1'b1};
          default: ;
        endcase
      end
      PAT_BLINKER: begin
        case (index)
          3'd0:    ent = '{2'd1, 2'd0, 1'b0};
          3'd1:    ent = '{2'd1, 2'd1, 1'b0};
          3'd2:    ent = '{2'd1, 2'd2, 1'b1};
          default: ;
        endcase
      end
      PAT_BLOCK: begin
        case (index)
          3'd0:    ent = '{2'd0, 2'd0, 1'b0};
          3'd1:    ent = '{2'd0, 2'd1, 1'b0};
          3'd2:    ent = '{2'd1, 2'd0, 1'b0};
          3'd3:    ent = '{2'd1, 2'd1, 1'b1};
          default: ;
        endcase
      end
      PAT_RPENT: begin
        case (index)
          3'd0:    ent = '{2'd0, 2'd1, 1'b0};
          3'd1:    ent = '{2'd0, 2'd2, 1'b0};
          3'd2:    ent = '{2'd1, 2'd0, 1'b0};
          3'd3:    ent = '{2'd1, 2'd1, 1'b0};
          3'd4:    ent = '{2'd2, 2'd1, 1'b1};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign dr   = ent.dr;
  assign dc   = ent.dc;
  assign last = ent.last;

endmodule

// File: rtl/pattern_writer.sv
// Clears the Life grid, seeds it with a selected pattern, then paces generation steps.
// All outputs are registered; the write address registers double as the clear sweep counter.
module pattern_writer #(
  parameter int GRID_BITS  = lifegame_pkg::GRID_BITS,
  parameter int GEN_PERIOD = 25000000,
  parameter int ORIGIN_R   = lifegame_pkg::DEFAULT_ORIGIN,
  parameter int ORIGIN_C   = lifegame_pkg::DEFAULT_ORIGIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           pattern_sel,
  input  logic                 run_en,
  output logic                 write_en,
  output logic [GRID_BITS-1:0] wAddrR,
  output logic [GRID_BITS-1:0] wAddrC,
  output logic                 write_data,
  output logic                 change_state,
  output logic                 busy,
  output logic                 done
);
  import lifegame_pkg::*;

  localparam int AW = 2 * GRID_BITS;
  localparam int TW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(GEN_PERIOD - 1);

  state_e                 state_q, state_d;
  pattern_e               pat_q, pat_d;
  logic [ROM_IDX_W-1:0]   idx_q, idx_d;
  logic                   last_q, last_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic                   we_q, we_d;
  logic [GRID_BITS-1:0]   ar_q, ar_d;
  logic [GRID_BITS-1:0]   ac_q, ac_d;
  logic                   wd_q, wd_d;
  logic                   cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [ROM_IDX_W-1:0]   rom_idx;
  logic [1:0]             rom_dr, rom_dc;
  logic                   rom_last;
  logic [GRID_BITS-1:0]   pat_r, pat_c;
  logic [AW-1:0]          clear_nxt;
  logic                   clear_last;

  // Index 0 is fetched during the final clear write so LOAD starts without a bubble.
  assign rom_idx = (state_q == LOAD) ? idx_q : '0;

  pattern_rom u_rom (
    .pattern (pat_q),
    .index   (rom_idx),
    .dr      (rom_dr),
    .dc      (rom_dc),
    .last    (rom_last)
  );

  always_comb begin
    pat_r      = GRID_BITS'(ORIGIN_R) + GRID_BITS'(rom_dr);
    pat_c      = GRID_BITS'(ORIGIN_C) + GRID_BITS'(rom_dc);
    clear_nxt  = {ar_q, ac_q} + AW'(1);
    clear_last = &{ar_q, ac_q};
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    last_d  = last_q;
    tick_d  = tick_q;
    we_d    = 1'b0;
    ar_d    = '0;
    ac_d    = '0;
    wd_d    = 1'b0;
    cs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          pat_d   = pattern_e'(pattern_sel);
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        if (clear_last) begin
          state_d = LOAD;
          wd_d    = 1'b1;
          ar_d    = pat_r;
          ac_d    = pat_c;
          last_d  = rom_last;
          idx_d   = ROM_IDX_W'(1);
        end else begin
          {ar_d, ac_d} = clear_nxt;
        end
      end
      LOAD: begin
        if (last_q) begin
          state_d = RUN;
          done_d  = 1'b1;
          tick_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          wd_d   = 1'b1;
          ar_d   = pat_r;
          ac_d   = pat_c;
          last_d = rom_last;
          idx_d  = idx_q + ROM_IDX_W'(1);
        end
      end
      RUN: begin
        // A restart wins over a step that would otherwise fire this cycle.
        if (start) begin
          state_d = CLEAR;
          pat_d   = pattern_e'(pattern_sel);
          tick_d  = '0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end else if (run_en) begin
          if (tick_q == TICK_MAX) begin
            tick_d = '0;
            cs_d   = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_GLIDER;
      idx_q   <= '0;
      last_q  <= 1'b0;
      tick_q  <= '0;
      we_q    <= 1'b0;
      ar_q    <= '0;
      ac_q    <= '0;
      wd_q    <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      tick_q  <= tick_d;
      we_q    <= we_d;
      ar_q    <= ar_d;
      ac_q    <= ac_d;
      wd_q    <= wd_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign write_en     = we_q;
  assign wAddrR       = ar_q;
  assign wAddrC       = ac_q;
  assign write_data   = wd_q;
  assign change_state = cs_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Scoreboard bench for pattern_writer: expected writes queued up front, popped per write cycle.
module tb_pattern_writer;
  import lifegame_pkg::*;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] c;
    logic       d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  exp_q[$];

  pattern_writer_if #(.GRID_BITS(6)) ifa ();
  pattern_writer_if #(.GRID_BITS(6)) ifb ();

  pattern_writer #(.GRID_BITS(6), .GEN_PERIOD(8), .ORIGIN_R(30), .ORIGIN_C(30)) dut0 (
    .clk (clk), .rst (rst),
    .start (ifa.start), .pattern_sel (ifa.pattern_sel), .run_en (ifa.run_en),
    .write_en (ifa.write_en), .wAddrR (ifa.wAddrR), .wAddrC (ifa.wAddrC),
    .write_data (ifa.write_data), .change_state (ifa.change_state),
    .busy (ifa.busy), .done (ifa.done)
  );

  pattern_writer #(.GRID_BITS(6), .GEN_PERIOD(8), .ORIGIN_R(63), .ORIGIN_C(63)) dut1 (
    .clk (clk), .rst (rst),
    .start (ifb.start), .pattern_sel (ifb.pattern_sel), .run_en (ifb.run_en),
    .write_en (ifb.write_en), .wAddrR (ifb.wAddrR), .wAddrC (ifb.wAddrC),
    .write_data (ifb.write_data), .change_state (ifb.change_state),
    .busy (ifb.busy), .done (ifb.done)
  );

  always #5 clk = ~clk;

  task automatic push_clear();
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(wr_t'{r: 6'(i / 64), c: 6'(i % 64), d: 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ifa.write_en, ifa.write_data, ifa.change_state, ifa.busy, ifa.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl_a got=%b exp=00000",
               {ifa.write_en, ifa.write_data, ifa.change_state, ifa.busy, ifa.done});
    end
    n_tests++;
    if ({ifa.wAddrR, ifa.wAddrC} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_addr_a got=%h exp=000", {ifa.wAddrR, ifa.wAddrC});
    end
    n_tests++;
    if (dut0.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", dut0.state_q, IDLE);
    end
    n_tests++;
    if ({ifb.write_en, ifb.write_data, ifb.change_state, ifb.busy, ifb.done,
         ifb.wAddrR, ifb.wAddrC} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_b got=%h exp=0",
               {ifb.write_en, ifb.write_data, ifb.change_state, ifb.busy, ifb.done, ifb.wAddrR, ifb.wAddrC});
    end
    @(posedge clk); #1 rst = 1'b0;
    // IDLE without start must stay quiet.
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ifa.write_en, ifa.busy, ifa.done} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_quiet got=%b exp=000", {ifa.write_en, ifa.busy, ifa.done});
    end
  endtask

  task automatic test_glider_load();
    wr_t e, got;
    push_clear();
    exp_q.push_back(wr_t'{6'd30, 6'd31, 1'b1});
    exp_q.push_back(wr_t'{6'd31, 6'd32, 1'b1});
    exp_q.push_back(wr_t'{6'd32, 6'd30, 1'b1});
    exp_q.push_back(wr_t'{6'd32, 6'd31, 1'b1});
    exp_q.push_back(wr_t'{6'd32, 6'd32, 1'b1});
    ifa.run_en = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b1; ifa.pattern_sel = 2'd0;
    @(posedge clk); #1 ifa.start = 1'b0; ifa.pattern_sel = 2'd3;
    for (int i = 0; i < 4101; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {ifa.wAddrR, ifa.wAddrC, ifa.write_data};
      n_tests++;
      if (ifa.write_en !== 1'b1 || got !== e || ifa.change_state !== 1'b0 || ifa.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL glider_wr[%0d] got we=%b busy=%b r=%0d c=%0d d=%b exp we=1 busy=1 r=%0d c=%0d d=%b",
                 i, ifa.write_en, ifa.busy, got.r, got.c, got.d, e.r, e.c, e.d);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({ifa.done, ifa.busy, ifa.write_en, ifa.write_data} !== 4'b1000) begin
      n_fail++;
      $display("FAIL glider_done got done/busy/we/wd=%b exp=1000",
               {ifa.done, ifa.busy, ifa.write_en, ifa.write_data});
    end
    n_tests++;
    if ({ifa.wAddrR, ifa.wAddrC} !== 12'd0) begin
      n_fail++;
      $display("FAIL glider_idle_addr got=%h exp=000", {ifa.wAddrR, ifa.wAddrC});
    end
  endtask

  task automatic test_gen_pulses();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_tests++;
      if (ifa.change_state !== ((k % 8) == 0) || ifa.done !== 1'b0 || ifa.write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL gen_pulse[%0d] got cs=%b done=%b we=%b exp cs=%b done=0 we=0",
                 k, ifa.change_state, ifa.done, ifa.write_en, ((k % 8) == 0));
      end
    end
  endtask

  // Pause of 5 cycles pushes the next step from +8 to +13; a restart lands where a step was due.
  task automatic test_run_pause();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      ifa.run_en = !(k >= 3 && k <= 7);
      if (k == 20) begin
        ifa.start = 1'b1;
        ifa.pattern_sel = 2'd1;
      end
      @(negedge clk);
      n_tests++;
      if (ifa.change_state !== (k == 13)) begin
        n_fail++;
        $display("FAIL pause_pulse[%0d] got cs=%b exp=%b", k, ifa.change_state, (k == 13));
      end
    end
  endtask

  task automatic test_restart_ignore_start();
    wr_t e, got;
    int  extra;
    push_clear();
    exp_q.push_back(wr_t'{6'd31, 6'd30, 1'b1});
    exp_q.push_back(wr_t'{6'd31, 6'd31, 1'b1});
    exp_q.push_back(wr_t'{6'd31, 6'd32, 1'b1});
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int i = 0; i < 4099; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {ifa.wAddrR, ifa.wAddrC, ifa.write_data};
      n_tests++;
      if (ifa.write_en !== 1'b1 || got !== e || ifa.change_state !== 1'b0) begin
        n_fail++;
        $display("FAIL blinker_wr[%0d] got we=%b cs=%b r=%0d c=%0d d=%b exp we=1 cs=0 r=%0d c=%0d d=%b",
                 i, ifa.write_en, ifa.change_state, got.r, got.c, got.d, e.r, e.c, e.d);
      end
      if (i == 100) begin ifa.start = 1'b1; ifa.pattern_sel = 2'd3; end
      if (i == 101) ifa.start = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if ({ifa.done, ifa.busy, ifa.write_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL blinker_done got done/busy/we=%b exp=100", {ifa.done, ifa.busy, ifa.write_en});
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifa.write_en === 1'b1) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL blinker_total got extra_writes=%0d exp=0", extra);
    end
  endtask

  task automatic test_origin_wrap();
    wr_t e, got;
    push_clear();
    exp_q.push_back(wr_t'{6'd63, 6'd63, 1'b1});
    exp_q.push_back(wr_t'{6'd63, 6'd0,  1'b1});
    exp_q.push_back(wr_t'{6'd0,  6'd63, 1'b1});
    exp_q.push_back(wr_t'{6'd0,  6'd0,  1'b1});
    @(posedge clk); #1 ifb.start = 1'b1; ifb.pattern_sel = 2'd2;
    @(posedge clk); #1 ifb.start = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {ifb.wAddrR, ifb.wAddrC, ifb.write_data};
      n_tests++;
      if (ifb.write_en !== 1'b1 || got !== e) begin
        n_fail++;
        $display("FAIL wrap_wr[%0d] got we=%b r=%0d c=%0d d=%b exp we=1 r=%0d c=%0d d=%b",
                 i, ifb.write_en, got.r, got.c, got.d, e.r, e.c, e.d);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({ifb.done, ifb.write_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL wrap_done got done/we=%b exp=10", {ifb.done, ifb.write_en});
    end
  endtask

  task automatic test_rst_abort();
    int cnt;
    int late;
    @(posedge clk); #1 ifa.start = 1'b1; ifa.pattern_sel = 2'd0;
    @(posedge clk); #1 ifa.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ifa.write_en === 1'b1) cnt++;
    end
    n_tests++;
    if (cnt !== 2000) begin
      n_fail++;
      $display("FAIL abort_pre_writes got=%0d exp=2000", cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ifa.write_en, ifa.write_data, ifa.change_state, ifa.busy, ifa.done,
         ifa.wAddrR, ifa.wAddrC} !== 17'b0) begin
      n_fail++;
      $display("FAIL abort_outputs got=%h exp=0",
               {ifa.write_en, ifa.write_data, ifa.change_state, ifa.busy, ifa.done, ifa.wAddrR, ifa.wAddrC});
    end
    n_tests++;
    if (dut0.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL abort_state got=%0d exp=%0d", dut0.state_q, IDLE);
    end
    late = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.write_en === 1'b1 || ifa.busy === 1'b1) late++;
    end
    n_tests++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL abort_no_writes got=%0d exp=0", late);
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.pattern_sel = 2'd0; ifa.run_en = 1'b0;
    ifb.start = 1'b0; ifb.pattern_sel = 2'd0; ifb.run_en = 1'b0;
    test_reset();
    test_glider_load();
    test_gen_pulses();
    test_run_pause();
    test_restart_ignore_start();
    test_origin_wrap();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_writer.md
PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 SHALL have parameter GRID_BITS, default 6, meaning row/column address width (64x64 grid).
REQ-002 SHALL have parameter GEN_PERIOD, default 25000000, meaning clk cycles between generation steps.
REQ-003 SHALL have parameters ORIGIN_R and ORIGIN_C, default 30 each, meaning the grid cell that pattern offsets are relative to.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a request to clear the grid and load a pattern.
REQ-007 SHALL have port pattern_sel, input, 2, meaning 0=glider, 1=blinker, 2=block, 3=R-pentomino.
REQ-008 SHALL have port run_en, input, 1, meaning generation stepping is enabled while high.
REQ-009 SHALL have port write_en, output, 1, meaning the write strobe to the evolve engine.
REQ-010 SHALL have ports wAddrR and wAddrC, output, GRID_BITS each, meaning the write row and column address.
REQ-011 SHALL have port write_data, output, 1, meaning the cell value written (1=alive).
REQ-012 SHALL have port change_state, output, 1, meaning a single-cycle pulse that advances one generation.
REQ-013 SHALL have port busy, output, 1, meaning high during CLEAR and LOAD.
REQ-014 SHALL have port done, output, 1, meaning a single-cycle pulse when loading completes.

Function
REQ-015 SHALL use FSM states IDLE, CLEAR, LOAD, RUN, and SHALL register every output.
REQ-016 SHALL, in IDLE with start=1 at edge N, enter CLEAR and latch pattern_sel, with the first write_en=1 visible in cycle N+1.
REQ-017 SHALL, in CLEAR, write_data=0 to all 4096 cells in row-major order (column fastest, (0,0) to (63,63)), one per cycle, using 4096 consecutive write_en cycles.
REQ-018 SHALL, on the write of (63,63), wrap the address counter to 0 and enter LOAD with no idle cycle.
REQ-019 SHALL, in LOAD, write write_data=1 to each pattern cell at (ORIGIN_R+dr, ORIGIN_C+dc), one per cycle, in ROM order, with address arithmetic modulo 2^GRID_BITS.
REQ-020 SHALL use these (dr,dc) offsets: glider (0,1)(1,2)(2,0)(2,1)(2,2); blinker (1,0)(1,1)(1,2); block (0,0)(0,1)(1,0)(1,1); R-pentomino (0,1)(0,2)(1,0)(1,1)(2,1).
REQ-021 SHALL, in the cycle after the last LOAD write, drive done=1 for exactly one cycle, drive busy=0 and write_en=0, and enter RUN.
REQ-022 SHALL, in RUN with run_en=1, count tick from 0 to GEN_PERIOD-1 and pulse change_state for one cycle when the count wraps; the first pulse SHALL occur GEN_PERIOD cycles after RUN entry.
REQ-023 SHALL, in RUN with run_en=0, hold tick and keep change_state=0; when run_en returns high, counting SHALL resume from the held value.
REQ-024 SHALL never assert change_state and write_en in the same cycle.
REQ-025 SHALL ignore start during CLEAR and LOAD.
REQ-026 SHALL, on start in RUN, clear tick, suppress any change_state pulse due in that cycle, and re-enter CLEAR with the newly latched pattern_sel.
REQ-027 SHALL hold write_data=0 and wAddrR=wAddrC=0 whenever write_en=0.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, enter IDLE and set write_en, write_data, change_state, busy, done, wAddrR, wAddrC, tick and the latched pattern to 0.
REQ-029 SHALL give rst priority over start, and rst during CLEAR or LOAD SHALL abort the sweep with no further writes.

Structure
REQ-030 SHALL place GRID_BITS, the FSM state encoding, the pattern codes and the default origin in a shared package lifegame_pkg.
REQ-031 SHALL implement offset lookup in a combinational sub-module pattern_rom (inputs pattern, index; outputs dr, dc, last).

Verification
REQ-032 SHALL check: rst then start with pattern_sel=0 -> 4096 writes of 0 in row-major order, then writes of 1 to (30,31)(31,32)(32,30)(32,31)(32,32), then done on the next cycle.
REQ-033 SHALL check: GEN_PERIOD=8, run_en=1 after done -> change_state pulses 8, 16 and 24 cycles after RUN entry, each one cycle wide.
REQ-034 SHALL check: run_en low for 5 cycles mid-count -> the next pulse is delayed by exactly 5 cycles.
REQ-035 SHALL check: start pulsed during CLEAR -> no restart, and total writes = 4096 + pattern size.
REQ-036 SHALL check: ORIGIN_R=ORIGIN_C=63 with block -> writes to (63,63)(63,0)(0,63)(0,0).
REQ-037 SHALL check: rst at write 2000 of CLEAR -> next cycle all outputs are 0 and the FSM is in IDLE.
